logic_axi4_lite_write_aligner: RTL and testbench

//  AXI4-Lite write-channel aligner. Accepts writes at any byte address, with data packed from lane 0, and

---
 rtl/logic_axi4_lite_write_aligner.sv | 235 +++++++++++++++++++++++
 tb/tb_logic_axi4_lite_write_aligner.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_axi4_lite_write_aligner.sv
// AXI4-Lite write aligner: shifts byte-addressed writes onto word-aligned master beats, splitting
// boundary-crossing writes and merging their responses. Option: LOGIC_AXI4_LITE_WRITE_ALIGNER_SKIP_EMPTY_EN.
module logic_axi4_lite_write_aligner #(
  parameter int unsigned DATA_BYTES    = 4,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned OUTSTANDING   = 4
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      slave_awvalid,
  input  logic [ADDRESS_WIDTH-1:0]  slave_awaddr,
  input  logic [2:0]                slave_awprot,
  output logic                      slave_awready,
  input  logic                      slave_wvalid,
  input  logic [DATA_BYTES*8-1:0]   slave_wdata,
  input  logic [DATA_BYTES-1:0]     slave_wstrb,
  output logic                      slave_wready,
  output logic                      slave_bvalid,
  output logic [1:0]                slave_bresp,
  input  logic                      slave_bready,
  output logic                      master_awvalid,
  output logic [ADDRESS_WIDTH-1:0]  master_awaddr,
  output logic [2:0]                master_awprot,
  input  logic                      master_awready,
  output logic                      master_wvalid,
  output logic [DATA_BYTES*8-1:0]   master_wdata,
  output logic [DATA_BYTES-1:0]     master_wstrb,
  input  logic                      master_wready,
  input  logic                      master_bvalid,
  input  logic [1:0]                master_bresp,
  output logic                      master_bready
);
  localparam int unsigned Off  = $clog2(DATA_BYTES);
  localparam int unsigned Dw   = DATA_BYTES * 8;
  localparam int unsigned PtrW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(OUTSTANDING + 1);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StSendLow  = 2'd1;
  localparam logic [1:0] StSendHigh = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] lo_addr_q, lo_addr_d, hi_addr_q, hi_addr_d;
  logic [Dw-1:0]            lo_data_q, lo_data_d, hi_data_q, hi_data_d;
  logic [DATA_BYTES-1:0]    lo_strb_q, lo_strb_d, hi_strb_q, hi_strb_d;
  logic [2:0]               prot_q, prot_d;
  logic                     split_q, split_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [OUTSTANDING-1:0]   fifo_q, fifo_d;
  logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     bvalid_q, bvalid_d, seen_q, seen_d;
  logic [1:0]               bresp_q, bresp_d, acc_q, acc_d;

  logic [Off-1:0]             off;
  logic [2*Dw-1:0]            data2;
  logic [2*DATA_BYTES-1:0]    strb2;
  logic [ADDRESS_WIDTH-1:0]   base_addr;
  logic                       issue_lo, issue_hi, idle, in_send, accept;
  logic                       aw_done_now, w_done_now, beat_done;
  logic                       fifo_full, fifo_empty, b_hs, b_last, pop;
  logic [1:0]                 b_mapped, b_worst;

  assign off       = slave_awaddr[Off-1:0];
  assign data2     = {{Dw{1'b0}}, slave_wdata} << {off, 3'b000};
  assign strb2     = {{DATA_BYTES{1'b0}}, slave_wstrb} << off;
  assign base_addr = {slave_awaddr[ADDRESS_WIDTH-1:Off], {Off{1'b0}}};

`ifdef LOGIC_AXI4_LITE_WRITE_ALIGNER_SKIP_EMPTY_EN
  logic lo_empty, hi_empty;
  assign lo_empty = ~|strb2[DATA_BYTES-1:0];
  assign hi_empty = ~|strb2[2*DATA_BYTES-1:DATA_BYTES];
  // An all-empty write still produces one LOW beat so the master sees a transaction.
  assign issue_lo = !lo_empty || hi_empty;
  assign issue_hi = !hi_empty;
`else
  assign issue_lo = 1'b1;
  assign issue_hi = (off != '0);
`endif

  assign fifo_full  = (cnt_q == CntW'(OUTSTANDING));
  assign fifo_empty = (cnt_q == '0);

  // Response merge: EXOKAY folds to OKAY, after which the encodings order by severity.
  assign b_hs     = master_bvalid && master_bready;
  assign b_mapped = (master_bresp == 2'b01) ? 2'b00 : master_bresp;
  assign b_worst  = (b_mapped > acc_q) ? b_mapped : acc_q;
  assign b_last   = seen_q || !fifo_q[rd_ptr_q];
  assign pop      = b_hs && !fifo_empty && b_last;

  assign idle          = (state_q == StIdle);
  assign slave_awready = !areset && idle && (!fifo_full || pop);
  assign slave_wready  = slave_awready;
  assign accept        = slave_awready && slave_awvalid && slave_wvalid;

  assign in_send        = (state_q == StSendLow) || (state_q == StSendHigh);
  assign master_awvalid = in_send && !aw_done_q;
  assign master_wvalid  = in_send && !w_done_q;
  assign master_awaddr  = (state_q == StSendHigh) ? hi_addr_q : lo_addr_q;
  assign master_wdata   = (state_q == StSendHigh) ? hi_data_q : lo_data_q;
  assign master_wstrb   = (state_q == StSendHigh) ? hi_strb_q : lo_strb_q;
  assign master_awprot  = prot_q;
  assign aw_done_now    = aw_done_q || (master_awvalid && master_awready);
  assign w_done_now     = w_done_q || (master_wvalid && master_wready);
  assign beat_done      = in_send && aw_done_now && w_done_now;

  assign master_bready = !areset && (!bvalid_q || slave_bready);
  assign slave_bvalid  = bvalid_q;
  assign slave_bresp   = bresp_q;

  always_comb begin
    state_d   = state_q;
    lo_addr_d = lo_addr_q;
    hi_addr_d = hi_addr_q;
    lo_data_d = lo_data_q;
    hi_data_d = hi_data_q;
    lo_strb_d = lo_strb_q;
    hi_strb_d = hi_strb_q;
    prot_d    = prot_q;
    split_d   = split_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          lo_addr_d = base_addr;
          hi_addr_d = base_addr + ADDRESS_WIDTH'(DATA_BYTES);
          lo_data_d = data2[Dw-1:0];
          hi_data_d = data2[2*Dw-1:Dw];
          lo_strb_d = strb2[DATA_BYTES-1:0];
          hi_strb_d = strb2[2*DATA_BYTES-1:DATA_BYTES];
          prot_d    = slave_awprot;
          split_d   = issue_hi;
          state_d   = issue_lo ? StSendLow : StSendHigh;
        end
      end
      StSendLow, StSendHigh: begin
        if (beat_done) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (state_q == StSendLow && split_q) ? StSendHigh : StIdle;
        end else begin
          aw_done_d = aw_done_now;
          w_done_d  = w_done_now;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (accept) begin
      fifo_d[wr_ptr_q] = issue_lo && issue_hi;
      wr_ptr_d = (wr_ptr_q == PtrW'(OUTSTANDING - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(OUTSTANDING - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    if (accept && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop && !accept) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_comb begin
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    acc_d    = acc_q;
    seen_d   = seen_q;
    if (bvalid_q && slave_bready) begin
      bvalid_d = 1'b0;
    end
    // B beats with nothing outstanding are accepted and dropped.
    if (b_hs && !fifo_empty) begin
      if (b_last) begin
        bvalid_d = 1'b1;
        bresp_d  = b_worst;
        acc_d    = 2'b00;
        seen_d   = 1'b0;
      end else begin
        acc_d  = b_worst;
        seen_d = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= StIdle;
      lo_addr_q <= '0;
      hi_addr_q <= '0;
      lo_data_q <= '0;
      hi_data_q <= '0;
      lo_strb_q <= '0;
      hi_strb_q <= '0;
      prot_q    <= '0;
      split_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      fifo_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      acc_q     <= 2'b00;
      seen_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lo_addr_q <= lo_addr_d;
      hi_addr_q <= hi_addr_d;
      lo_data_q <= lo_data_d;
      hi_data_q <= hi_data_d;
      lo_strb_q <= lo_strb_d;
      hi_strb_q <= hi_strb_d;
      prot_q    <= prot_d;
      split_q   <= split_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      acc_q     <= acc_d;
      seen_q    <= seen_d;
    end
  end

endmodule

// File: tb/tb_logic_axi4_lite_write_aligner.sv
// Randomized bench for logic_axi4_lite_write_aligner: per-byte reference model, random master
// readiness and responses, directed corner writes, backpressure and mid-transaction reset.
module tb_logic_axi4_lite_write_aligner;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        slave_awvalid = 1'b0;
  logic [31:0] slave_awaddr = '0;
  logic [2:0]  slave_awprot = '0;
  logic        slave_awready;
  logic        slave_wvalid = 1'b0;
  logic [31:0] slave_wdata = '0;
  logic [3:0]  slave_wstrb = '0;
  logic        slave_wready;
  logic        slave_bvalid;
  logic [1:0]  slave_bresp;
  logic        slave_bready = 1'b0;
  logic        master_awvalid;
  logic [31:0] master_awaddr;
  logic [2:0]  master_awprot;
  logic        master_awready = 1'b0;
  logic        master_wvalid;
  logic [31:0] master_wdata;
  logic [3:0]  master_wstrb;
  logic        master_wready = 1'b0;
  logic        master_bvalid = 1'b0;
  logic [1:0]  master_bresp = 2'b00;
  logic        master_bready;

  logic_axi4_lite_write_aligner #(
    .DATA_BYTES(4), .ADDRESS_WIDTH(32), .OUTSTANDING(4)
  ) dut (
    .aclk(aclk), .areset(areset),
    .slave_awvalid(slave_awvalid), .slave_awaddr(slave_awaddr), .slave_awprot(slave_awprot),
    .slave_awready(slave_awready), .slave_wvalid(slave_wvalid), .slave_wdata(slave_wdata),
    .slave_wstrb(slave_wstrb), .slave_wready(slave_wready), .slave_bvalid(slave_bvalid),
    .slave_bresp(slave_bresp), .slave_bready(slave_bready),
    .master_awvalid(master_awvalid), .master_awaddr(master_awaddr),
    .master_awprot(master_awprot), .master_awready(master_awready),
    .master_wvalid(master_wvalid), .master_wdata(master_wdata), .master_wstrb(master_wstrb),
    .master_wready(master_wready), .master_bvalid(master_bvalid), .master_bresp(master_bresp),
    .master_bready(master_bready)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_fail = 0;

  // Captured traffic
  logic [34:0] got_aw_q[$];
  logic [35:0] got_w_q[$];
  logic [1:0]  got_b_q[$];
  int n_aw = 0;
  int n_w = 0;

  // Reference model expectations
  logic [34:0] exp_aw_q[$];
  logic [35:0] exp_w_q[$];
  int          exp_beats_q[$];
  int aw_rd = 0, w_rd = 0, b_rd = 0, resp_rd = 0;

  // Master-side responder controls
  int ready_mode = 0;  // 0: always ready, 1: random, 2: never
  int b_limit = 1000000;
  logic [1:0] plan [4];
  int plan_base = 0, plan_len = 0;
  int n_issued = 0;
  logic [1:0] sent_resp_q[$];

  always @(negedge aclk) begin
    if (!areset) begin
      if (master_awvalid && master_awready) begin
        got_aw_q.push_back({master_awprot, master_awaddr});
        n_aw++;
      end
      if (master_wvalid && master_wready) begin
        got_w_q.push_back({master_wdata, master_wstrb});
        n_w++;
      end
      if (slave_bvalid && slave_bready) got_b_q.push_back(slave_bresp);
    end
  end

  always @(posedge aclk) begin
    #2;
    case (ready_mode)
      0: begin master_awready = 1'b1; master_wready = 1'b1; slave_bready = 1'b1; end
      1: begin
        master_awready = 1'($urandom_range(0, 1));
        master_wready  = 1'($urandom_range(0, 1));
        slave_bready   = 1'($urandom_range(0, 1));
      end
      default: begin master_awready = 1'b0; master_wready = 1'b0; slave_bready = 1'b1; end
    endcase
  end

  always begin : responder
    logic hs;
    int done, idx;
    logic [1:0] r;
    @(negedge aclk);
    hs = master_bvalid && master_bready;
    @(posedge aclk);
    #2;
    done = (n_aw < n_w) ? n_aw : n_w;
    if (areset) begin
      master_bvalid = 1'b0;
      n_issued = done;
    end else begin
      if (hs) master_bvalid = 1'b0;
      if (!master_bvalid && n_issued < done && n_issued < b_limit && $urandom_range(0, 2) != 0) begin
        idx = n_issued - plan_base;
        r = (idx >= 0 && idx < plan_len) ? plan[idx] : 2'($urandom_range(0, 3));
        master_bvalid = 1'b1;
        master_bresp  = r;
        sent_resp_q.push_back(r);
        n_issued++;
      end
    end
  end

  function automatic int rank(input logic [1:0] r);
    case (r)
      2'b11:   return 2;
      2'b10:   return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [1:0] unrank(input int k);
    return (k == 2) ? 2'b11 : (k == 1) ? 2'b10 : 2'b00;
  endfunction

  // Places each byte at its absolute address and derives the beats from which words get touched.
  task automatic model_push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [2:0] p);
    int off;
    logic [31:0] lo_d, hi_d, base;
    logic [3:0] lo_s, hi_s;
    bit do_lo, do_hi;
    off = int'(a % 4);
    lo_d = '0; hi_d = '0; lo_s = '0; hi_s = '0;
    for (int i = 0; i < 4; i++) begin
      if (off + i < 4) begin
        lo_d[8*(off+i) +: 8] = d[8*i +: 8];
        lo_s[off+i] = s[i];
      end else begin
        hi_d[8*(off+i-4) +: 8] = d[8*i +: 8];
        hi_s[off+i-4] = s[i];
      end
    end
    base = a - 32'(off);
`ifdef LOGIC_AXI4_LITE_WRITE_ALIGNER_SKIP_EMPTY_EN
    do_hi = (hi_s != 0);
    do_lo = (lo_s != 0) || !do_hi;
`else
    do_lo = 1'b1;
    do_hi = (off != 0);
`endif
    if (do_lo) begin exp_aw_q.push_back({p, base}); exp_w_q.push_back({lo_d, lo_s}); end
    if (do_hi) begin exp_aw_q.push_back({p, base + 32'd4}); exp_w_q.push_back({hi_d, hi_s}); end
    exp_beats_q.push_back(int'(do_lo) + int'(do_hi));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [2:0] p, input int max_cyc, output bit acc);
    acc = 1'b0;
    @(posedge aclk);
    #1;
    slave_awvalid = 1'b1; slave_wvalid = 1'b1;
    slave_awaddr = a; slave_wdata = d; slave_wstrb = s; slave_awprot = p;
    for (int c = 0; c < max_cyc && !acc; c++) begin
      @(negedge aclk);
      n_cmp++;
      if (slave_wready !== slave_awready) begin
        n_fail++;
        $display("FAIL ready_pair: wready=%b awready=%b", slave_wready, slave_awready);
      end
      if (slave_awready === 1'b1) begin
        acc = 1'b1;
        model_push(a, d, s, p);
      end
      @(posedge aclk);
      #1;
    end
    slave_awvalid = 1'b0; slave_wvalid = 1'b0;
  endtask

  task automatic drain_and_check(input string name);
    int need, c, ri, worst;
    need = exp_beats_q.size();
    c = 0;
    while (got_b_q.size() - b_rd < need && c < 4000) begin @(negedge aclk); c++; end
    repeat (8) @(negedge aclk);
    n_cmp++;
    if (got_b_q.size() - b_rd != need) begin
      n_fail++;
      $display("FAIL %s b_count: got %0d want %0d", name, got_b_q.size() - b_rd, need);
    end
    n_cmp++;
    if (got_aw_q.size() - aw_rd != exp_aw_q.size() || got_w_q.size() - w_rd != exp_w_q.size()) begin
      n_fail++;
      $display("FAIL %s beat_count: aw %0d w %0d want %0d", name, got_aw_q.size() - aw_rd,
               got_w_q.size() - w_rd, exp_aw_q.size());
    end
    for (int i = 0; i < exp_aw_q.size() && aw_rd + i < got_aw_q.size(); i++) begin
      n_cmp++;
      if (got_aw_q[aw_rd+i] !== exp_aw_q[i]) begin
        n_fail++;
        $display("FAIL %s aw[%0d]: got %h want %h", name, i, got_aw_q[aw_rd+i], exp_aw_q[i]);
      end
    end
    for (int i = 0; i < exp_w_q.size() && w_rd + i < got_w_q.size(); i++) begin
      n_cmp++;
      if (got_w_q[w_rd+i] !== exp_w_q[i]) begin
        n_fail++;
        $display("FAIL %s w[%0d]: got %h want %h", name, i, got_w_q[w_rd+i], exp_w_q[i]);
      end
    end
    ri = resp_rd;
    for (int k = 0; k < need && b_rd + k < got_b_q.size(); k++) begin
      worst = 0;
      for (int j = 0; j < exp_beats_q[k]; j++) begin
        if (ri < sent_resp_q.size() && rank(sent_resp_q[ri]) > worst) worst = rank(sent_resp_q[ri]);
        ri++;
      end
      n_cmp++;
      if (got_b_q[b_rd+k] !== unrank(worst)) begin
        n_fail++;
        $display("FAIL %s bresp[%0d]: got %b want %b", name, k, got_b_q[b_rd+k], unrank(worst));
      end
    end
    aw_rd = got_aw_q.size(); w_rd = got_w_q.size(); b_rd = got_b_q.size();
    resp_rd = sent_resp_q.size();
    exp_aw_q.delete(); exp_w_q.delete(); exp_beats_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge aclk);
    n_cmp++;
    if ({slave_awready, slave_wready, slave_bvalid, slave_bresp, master_awvalid, master_wvalid,
         master_bready} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: awr=%b wr=%b bv=%b br=%b mawv=%b mwv=%b mbr=%b", slave_awready,
               slave_wready, slave_bvalid, slave_bresp, master_awvalid, master_wvalid, master_bready);
    end
    @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    n_cmp++;
    if (slave_awready !== 1'b1 || master_bready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_ready: awready=%b bready=%b want 1 1", slave_awready, master_bready);
    end
    n_cmp++;
    if (master_awvalid !== 1'b0 || slave_bvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: awvalid=%b bvalid=%b want 0 0", master_awvalid, slave_bvalid);
    end
  endtask

  task automatic test_aligned();
    bit acc;
    int a0, w0, b0;
    a0 = aw_rd; w0 = w_rd; b0 = b_rd;
    plan_base = n_issued; plan[0] = 2'b00; plan_len = 1;
    do_write(32'h100, 32'hAABBCCDD, 4'hF, 3'b010, 50, acc);
    drain_and_check("aligned");
    n_cmp++;
    if (aw_rd - a0 != 1 || got_aw_q[a0][31:0] !== 32'h100 || got_w_q[w0] !== {32'hAABBCCDD, 4'hF}
        || got_b_q[b0] !== 2'b00) begin
      n_fail++;
      $display("FAIL aligned_literal: beats=%0d aw=%h w=%h b=%b want 1 100 aabbccdd_f 00",
               aw_rd - a0, got_aw_q[a0], got_w_q[w0], got_b_q[b0]);
    end
  endtask

  task automatic test_split();
    bit acc;
    int a0, w0, b0;
    a0 = aw_rd; w0 = w_rd; b0 = b_rd;
    plan_base = n_issued; plan[0] = 2'b00; plan[1] = 2'b10; plan_len = 2;
    do_write(32'h103, 32'h44332211, 4'hF, 3'b001, 50, acc);
    drain_and_check("split");
    n_cmp++;
    if (got_aw_q[a0][31:0] !== 32'h100 || got_aw_q[a0+1][31:0] !== 32'h104) begin
      n_fail++;
      $display("FAIL split_addr: got %h %h want 100 104", got_aw_q[a0], got_aw_q[a0+1]);
    end
    n_cmp++;
    if (got_w_q[w0] !== {32'h11000000, 4'h8} || got_w_q[w0+1] !== {32'h00443322, 4'h7}) begin
      n_fail++;
      $display("FAIL split_data: got %h %h want 11000000_8 00443322_7", got_w_q[w0], got_w_q[w0+1]);
    end
    n_cmp++;
    if (got_b_q[b0] !== 2'b10) begin
      n_fail++;
      $display("FAIL split_bresp: got %b want 10", got_b_q[b0]);
    end
  endtask

  task automatic test_wrap();
    bit acc;
    int a0;
    a0 = aw_rd;
    plan_len = 0;
    do_write(32'hFFFF_FFFE, $urandom, 4'hF, 3'b000, 50, acc);
    drain_and_check("wrap");
    n_cmp++;
    if (got_aw_q[a0][31:0] !== 32'hFFFF_FFFC || got_aw_q[a0+1][31:0] !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_addr: got %h %h want fffffffc 00000000", got_aw_q[a0], got_aw_q[a0+1]);
    end
  endtask

  task automatic test_zero_strobe();
    bit acc;
    int a0, w0;
    a0 = aw_rd; w0 = w_rd;
    do_write(32'h102, 32'h0000BBAA, 4'h3, 3'b000, 50, acc);
    drain_and_check("zero_strobe");
    n_cmp++;
`ifdef LOGIC_AXI4_LITE_WRITE_ALIGNER_SKIP_EMPTY_EN
    if (aw_rd - a0 != 1 || got_w_q[w0][3:0] !== 4'hC) begin
      n_fail++;
      $display("FAIL zero_strobe_beats: beats=%0d strb=%h want 1 c", aw_rd - a0, got_w_q[w0][3:0]);
    end
`else
    if (aw_rd - a0 != 2 || got_w_q[w0][3:0] !== 4'hC || got_w_q[w0+1][3:0] !== 4'h0
        || got_aw_q[a0+1][31:0] !== 32'h104) begin
      n_fail++;
      $display("FAIL zero_strobe_beats: beats=%0d strb=%h,%h addr2=%h want 2 c,0 104", aw_rd - a0,
               got_w_q[w0][3:0], got_w_q[w0+1][3:0], got_aw_q[a0+1][31:0]);
    end
`endif
  endtask

  task automatic test_backpressure();
    bit acc;
    int n_acc;
    b_limit = n_issued;
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      do_write({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom, 4'hF, 3'b000, 20, acc);
      n_acc += int'(acc);
    end
    n_cmp++;
    if (n_acc != 4) begin
      n_fail++;
      $display("FAIL bp_first_four: accepted %0d want 4", n_acc);
    end
    repeat (3) @(negedge aclk);
    n_cmp++;
    if (slave_awready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full_awready: got %b want 0", slave_awready);
    end
    do_write(32'h200, $urandom, 4'hF, 3'b000, 10, acc);
    n_cmp++;
    if (acc) begin n_fail++; $display("FAIL bp_fifth_blocked: accepted 1 want 0"); end
    b_limit = n_issued + 1;
    do_write(32'h200, $urandom, 4'hF, 3'b000, 20, acc);
    n_cmp++;
    if (!acc) begin n_fail++; $display("FAIL bp_fifth_after_b: accepted 0 want 1"); end
    do_write(32'h300, $urandom, 4'hF, 3'b000, 10, acc);
    n_cmp++;
    if (acc) begin n_fail++; $display("FAIL bp_sixth_blocked: accepted 1 want 0"); end
    b_limit = 1000000;
    do_write(32'h300, $urandom, 4'hF, 3'b000, 50, acc);
    drain_and_check("backpressure");
  endtask

  task automatic test_random();
    bit acc;
    logic [31:0] a;
    ready_mode = 1;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      do_write(a, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 200, acc);
      n_cmp++;
      if (!acc) begin n_fail++; $display("FAIL random_accept[%0d]: accepted 0 want 1", i); end
    end
    drain_and_check("random");
    ready_mode = 0;
  endtask

  task automatic test_reset_mid();
    bit acc, seen;
    b_limit = n_issued;
    ready_mode = 0;
    do_write(32'h501, $urandom, 4'hF, 3'b000, 50, acc);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge aclk);
      if (master_awvalid && master_awready && master_wvalid && master_wready) begin
        seen = 1'b1;
        ready_mode = 2;
      end
    end
    @(negedge aclk);
    n_cmp++;
    if (master_awvalid !== 1'b1 || master_awaddr !== 32'h504) begin
      n_fail++;
      $display("FAIL mid_high_pending: awvalid=%b addr=%h want 1 504", master_awvalid, master_awaddr);
    end
    @(posedge aclk);
    #1 areset = 1'b1;
    @(negedge aclk);
    n_cmp++;
    if (master_awvalid !== 1'b0 || master_wvalid !== 1'b0 || slave_bvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_idle: awvalid=%b wvalid=%b bvalid=%b want 0 0 0", master_awvalid,
               master_wvalid, slave_bvalid);
    end
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    ready_mode = 0;
    b_limit = 1000000;
    @(negedge aclk);
    aw_rd = got_aw_q.size(); w_rd = got_w_q.size(); b_rd = got_b_q.size();
    resp_rd = sent_resp_q.size();
    exp_aw_q.delete(); exp_w_q.delete(); exp_beats_q.delete();
    do_write(32'h702, $urandom, 4'hF, 3'b100, 50, acc);
    drain_and_check("after_reset");
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_split();
    test_wrap();
    test_zero_strobe();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
